// File: rtl/instr_fetch_sequencer_if.sv
// Fetch sequencer bundle: PC/decode handshake plus byte-wide memory bus.
// master = sequencer side, slave = PC logic / decode / memory side.
interface instr_fetch_sequencer_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] pc_in;
    logic            fetch_req;
    logic            flush;
    logic            instr_ready;
    logic [31:0]     instruction;
    logic            instr_valid;
    logic            fetch_busy;
    logic            align_err;
    logic            bus_err;
    logic            mem_read;
    logic [PC_W-1:0] mem_addr;
    logic [7:0]      mem_rdata;
    logic            mem_ack;

    modport master (
        input  pc_in, fetch_req, flush, instr_ready,
        input  mem_rdata, mem_ack,
        output instruction, instr_valid, fetch_busy,
        output align_err, bus_err, mem_read, mem_addr
    );

    modport slave (
        output pc_in, fetch_req, flush, instr_ready,
        output mem_rdata, mem_ack,
        input  instruction, instr_valid, fetch_busy,
        input  align_err, bus_err, mem_read, mem_addr
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Four-byte big-endian instruction fetch over a byte-wide memory bus.
// Ports: CLK, RESET_N (async low), bus (instr_fetch_sequencer_if.master).
module instr_fetch_sequencer #(
    parameter int PC_W    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    instr_fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t          state;
    state_t          state_n;
    logic [PC_W-1:0] base;
    logic [1:0]      idx;
    logic [7:0]      wcnt;
    logic [23:0]     shreg;
    logic [31:0]     instr_q;
    logic            align_q;
    logic            bus_q;

    logic handoff;
    logic aligned;
    logic do_launch;
    logic do_align;
    logic do_ack;
    logic do_tmo;

    // A new fetch may be accepted from IDLE, on the DONE
    // consume edge, or as the restart half of a flush.
    always_comb begin
        handoff   = bus.flush || (state == IDLE) ||
                    ((state == DONE) && bus.instr_ready);
        aligned   = (bus.pc_in[1:0] == 2'b00);
        do_launch = handoff && bus.fetch_req && aligned;
        do_align  = handoff && bus.fetch_req && !aligned;
        do_ack    = !bus.flush && (state == READ) && bus.mem_ack;
        do_tmo    = !bus.flush && (state == READ) &&
                    !bus.mem_ack && (wcnt == TMAX);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (do_launch) begin
            state_n = READ;
        end else if (bus.flush) begin
            state_n = IDLE;
        end else begin
            unique case (1'b1)
                (state == IDLE): state_n = IDLE;
                (state == READ): begin
                    if (do_ack && (idx == 2'd3)) begin
                        state_n = DONE;
                    end else if (do_tmo) begin
                        state_n = IDLE;
                    end
                end
                (state == DONE): begin
                    if (bus.instr_ready) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_read    = (state == READ);
        bus.mem_addr    = base + PC_W'(idx);
        bus.instr_valid = (state == DONE);
        bus.fetch_busy  = (state != IDLE);
        bus.instruction = instr_q;
        bus.align_err   = align_q;
        bus.bus_err     = bus_q;
    end

    // Bytes shift in MSB-first, so the fourth byte completes
    // the big-endian word; idx wraps back to 0 after byte 3.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            base    <= '0;
            idx     <= '0;
            wcnt    <= '0;
            shreg   <= '0;
            instr_q <= '0;
            align_q <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            align_q <= do_align;
            bus_q   <= do_tmo;
            if (do_launch) begin
                base <= bus.pc_in;
                idx  <= '0;
                wcnt <= '0;
            end else if (bus.flush || do_tmo) begin
                idx  <= '0;
                wcnt <= '0;
            end else if (do_ack) begin
                shreg <= {shreg[15:0], bus.mem_rdata};
                wcnt  <= '0;
                idx   <= idx + 2'd1;
                if (idx == 2'd3) begin
                    instr_q <= {shreg, bus.mem_rdata};
                end
            end else if (state == READ) begin
                wcnt <= wcnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Randomized self-checking bench for instr_fetch_sequencer.
// Reference: word = concatenation of memory bytes at pc..pc+3.
module tb_instr_fetch_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    instr_fetch_sequencer_if #(.PC_W(32)) ifc ();

    instr_fetch_sequencer #(.PC_W(32), .TIMEOUT(15)) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .bus(ifc)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h10:  return 8'h04;
            32'h11:  return 8'h02;
            32'h12:  return 8'h00;
            32'h13:  return 8'h05;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        return {mem_byte(pc), mem_byte(pc + 32'd1),
                mem_byte(pc + 32'd2), mem_byte(pc + 32'd3)};
    endfunction

    task automatic start_fetch(input logic [31:0] pc);
        ifc.fetch_req = 1'b1;
        ifc.pc_in     = pc;
        @(negedge clk);
        ifc.fetch_req = 1'b0;
    endtask

    task automatic consume();
        ifc.instr_ready = 1'b1;
        @(negedge clk);
        ifc.instr_ready = 1'b0;
    endtask

    // Serve four bytes with random ack gaps; count bus anomalies.
    task automatic do_bytes(input logic [31:0] pc, input int maxgap,
                            output logic [31:0] word,
                            output int addr_bad, output int cycles,
                            output bit to);
        int k;
        int gap;
        k = 0;
        addr_bad = 0;
        cycles = 0;
        to = 1'b0;
        gap = $urandom_range(maxgap, 0);
        while (k < 4) begin
            if (cycles >= 200) begin
                to = 1'b1;
                break;
            end
            if (ifc.mem_read !== 1'b1 || ifc.mem_addr !== pc + 32'(k) ||
                ifc.fetch_busy !== 1'b1 || ifc.instr_valid !== 1'b0)
                addr_bad++;
            if (gap > 0) begin
                ifc.mem_ack = 1'b0;
                gap--;
            end else begin
                ifc.mem_ack   = 1'b1;
                ifc.mem_rdata = mem_byte(pc + 32'(k));
                k++;
                gap = $urandom_range(maxgap, 0);
            end
            @(negedge clk);
            cycles++;
        end
        ifc.mem_ack   = 1'b0;
        ifc.mem_rdata = $urandom;
        word = ifc.instruction;
    endtask

    task automatic check_word(input string nm, input logic [31:0] pc,
                              input logic [31:0] w, input int ab,
                              input bit to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL %s timeout: fetch never completed", nm);
        end
        total++;
        if (ab !== 0) begin
            bad++;
            $display("FAIL %s bus: %0d bad cycles, want 0", nm, ab);
        end
        total++;
        if (w !== model_word(pc) || ifc.instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s word: got %h v=%b want %h v=1", nm, w,
                     ifc.instr_valid, model_word(pc));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (ifc.instruction !== 32'h0 || ifc.instr_valid !== 1'b0 ||
            ifc.fetch_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: instr=%h v=%b busy=%b want 0/0/0",
                     ifc.instruction, ifc.instr_valid, ifc.fetch_busy);
        end
        total++;
        if (ifc.mem_read !== 1'b0 || ifc.mem_addr !== 32'h0 ||
            ifc.align_err !== 1'b0 || ifc.bus_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_bus: rd=%b addr=%h ae=%b be=%b want 0",
                     ifc.mem_read, ifc.mem_addr, ifc.align_err,
                     ifc.bus_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] w;
        int ab, cy;
        bit to;
        start_fetch(32'h10);
        do_bytes(32'h10, 0, w, ab, cy, to);
        check_word("basic", 32'h10, w, ab, to);
        total++;
        if (cy !== 4 || w !== 32'h04020005) begin
            bad++;
            $display("FAIL basic_lat: cycles=%0d w=%h want 4 04020005",
                     cy, w);
        end
        consume();
        total++;
        if (ifc.fetch_busy !== 1'b0 || ifc.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: busy=%b v=%b want 0 0",
                     ifc.fetch_busy, ifc.instr_valid);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] pc, w;
        int ab, cy;
        bit to;
        for (int i = 0; i < 6; i++) begin
            pc = {$urandom, 2'b00};
            start_fetch(pc);
            do_bytes(pc, 3, w, ab, cy, to);
            check_word("gaps", pc, w, ab, to);
            consume();
        end
    endtask

    task automatic test_align();
        ifc.fetch_req = 1'b1;
        ifc.pc_in = 32'h11;
        @(negedge clk);
        ifc.fetch_req = 1'b0;
        total++;
        if (ifc.align_err !== 1'b1 || ifc.mem_read !== 1'b0 ||
            ifc.fetch_busy !== 1'b0 || ifc.bus_err !== 1'b0) begin
            bad++;
            $display("FAIL align_pulse: ae=%b rd=%b busy=%b be=%b want 1000",
                     ifc.align_err, ifc.mem_read, ifc.fetch_busy,
                     ifc.bus_err);
        end
        @(negedge clk);
        total++;
        if (ifc.align_err !== 1'b0 || ifc.mem_read !== 1'b0) begin
            bad++;
            $display("FAIL align_end: ae=%b rd=%b want 0 0",
                     ifc.align_err, ifc.mem_read);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] prev;
        int n, busy_bad;
        bit seen;
        prev = ifc.instruction;
        ifc.mem_ack = 1'b0;
        start_fetch(32'h20);
        n = 0;
        busy_bad = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (ifc.bus_err === 1'b1) seen = 1'b1;
            else if (ifc.fetch_busy !== 1'b1) busy_bad++;
        end
        total++;
        if (!seen || n !== 15 || busy_bad !== 0) begin
            bad++;
            $display("FAIL timeout_at: seen=%b n=%0d busybad=%0d want 1 15 0",
                     seen, n, busy_bad);
        end
        total++;
        if (ifc.fetch_busy !== 1'b0 || ifc.instruction !== prev ||
            ifc.align_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: busy=%b instr=%h ae=%b want 0 %h 0",
                     ifc.fetch_busy, ifc.instruction, ifc.align_err, prev);
        end
        @(negedge clk);
        total++;
        if (ifc.bus_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: bus_err=%b want 0", ifc.bus_err);
        end
    endtask

    task automatic test_flush();
        logic [31:0] w, prev;
        int ab, cy;
        bit to;
        start_fetch(32'h30);
        for (int i = 0; i < 2; i++) begin
            ifc.mem_ack = 1'b1;
            ifc.mem_rdata = mem_byte(32'h30 + 32'(i));
            @(negedge clk);
        end
        ifc.flush = 1'b1;
        ifc.fetch_req = 1'b1;
        ifc.pc_in = 32'h40;
        ifc.mem_rdata = 8'hEE;
        @(negedge clk);
        ifc.flush = 1'b0;
        ifc.fetch_req = 1'b0;
        ifc.mem_ack = 1'b0;
        total++;
        if (ifc.mem_addr !== 32'h40 || ifc.mem_read !== 1'b1 ||
            ifc.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_restart: addr=%h rd=%b v=%b want 40 1 0",
                     ifc.mem_addr, ifc.mem_read, ifc.instr_valid);
        end
        do_bytes(32'h40, 2, w, ab, cy, to);
        check_word("flush", 32'h40, w, ab, to);
        consume();
        prev = ifc.instruction;
        start_fetch(32'h50);
        for (int i = 0; i < 3; i++) begin
            ifc.mem_ack = 1'b1;
            ifc.mem_rdata = mem_byte(32'h50 + 32'(i));
            @(negedge clk);
        end
        ifc.mem_rdata = mem_byte(32'h53);
        ifc.flush = 1'b1;
        @(negedge clk);
        ifc.flush = 1'b0;
        ifc.mem_ack = 1'b0;
        total++;
        if (ifc.instr_valid !== 1'b0 || ifc.fetch_busy !== 1'b0 ||
            ifc.instruction !== prev || ifc.mem_read !== 1'b0) begin
            bad++;
            $display("FAIL flush_last: v=%b busy=%b instr=%h rd=%b want 0 0 %h 0",
                     ifc.instr_valid, ifc.fetch_busy, ifc.instruction,
                     ifc.mem_read, prev);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] w, held, nxt;
        int ab, cy, hold_bad;
        bit to;
        start_fetch(32'hFFFF_FFFC);
        do_bytes(32'hFFFF_FFFC, 1, w, ab, cy, to);
        check_word("wrap", 32'hFFFF_FFFC, w, ab, to);
        held = ifc.instruction;
        nxt = {$urandom_range(255, 0), 2'b00};
        ifc.fetch_req = 1'b1;
        ifc.pc_in = nxt;
        hold_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ifc.instruction !== held || ifc.instr_valid !== 1'b1 ||
                ifc.mem_read !== 1'b0)
                hold_bad++;
        end
        total++;
        if (hold_bad !== 0) begin
            bad++;
            $display("FAIL wrap_hold: %0d unstable cycles want 0", hold_bad);
        end
        ifc.instr_ready = 1'b1;
        @(negedge clk);
        ifc.instr_ready = 1'b0;
        ifc.fetch_req = 1'b0;
        total++;
        if (ifc.mem_addr !== nxt || ifc.mem_read !== 1'b1 ||
            ifc.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL wrap_handoff: addr=%h rd=%b v=%b want %h 1 0",
                     ifc.mem_addr, ifc.mem_read, ifc.instr_valid, nxt);
        end
        do_bytes(nxt, 2, w, ab, cy, to);
        check_word("wrap_next", nxt, w, ab, to);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc, w;
        int ab, cy;
        bit to;
        for (int i = 0; i < 3; i++) begin
            pc = {$urandom, 2'b00};
            ifc.instr_ready = 1'b1;
            ifc.fetch_req = 1'b1;
            ifc.pc_in = pc;
            @(negedge clk);
            ifc.instr_ready = 1'b0;
            ifc.fetch_req = 1'b0;
            do_bytes(pc, 0, w, ab, cy, to);
            check_word("b2b", pc, w, ab, to);
            total++;
            if (cy !== 4) begin
                bad++;
                $display("FAIL b2b_rate: cycles=%0d want 4", cy);
            end
        end
        consume();
    endtask

    initial begin
        ifc.pc_in = '0;
        ifc.fetch_req = 1'b0;
        ifc.flush = 1'b0;
        ifc.instr_ready = 1'b0;
        ifc.mem_rdata = '0;
        ifc.mem_ack = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_align();
        test_timeout();
        test_flush();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
